// File: rtl/param_cpu_core.sv
// Parametrised multi-cycle CPU core: register file, synchronous data memory, flagged ALU,
// and an IDLE/DECODE/EXECUTE/MEM/WRITEBACK sequencer fed through a valid/ready handshake.
module param_cpu_core #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_BITS     = 5,
  parameter int REG_ADDR_BITS = 2,
  parameter int INSTR_WIDTH   = 6 + 3 * REG_ADDR_BITS + DATA_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [INSTR_WIDTH-1:0]                     instr,
  input  logic                                       instr_valid,
  output logic                                       instr_ready,
  output logic                                       retire,
  output logic                                       illegal_op,
  output logic                                       flag_z,
  output logic                                       flag_c,
  output logic [(2**REG_ADDR_BITS)*DATA_WIDTH-1:0]   regs_flat
);

  localparam int NUM_REGS  = 2 ** REG_ADDR_BITS;
  localparam int MEM_WORDS = 2 ** ADDR_BITS;

  localparam logic [1:0] CLS_NOP   = 2'b00;
  localparam logic [1:0] CLS_ALU   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
  logic [DATA_WIDTH-1:0]    opa_q, opa_d, opb_q, opb_d, opz_q, opz_d;
  logic [DATA_WIDTH-1:0]    alu_q, alu_d, rdata_q, rdata_d;
  logic                     carry_q, carry_d;
  logic [ADDR_BITS-1:0]     addr_q, addr_d;
  logic                     retire_q, retire_d, illegal_q, illegal_d;
  logic                     flag_z_q, flag_z_d, flag_c_q, flag_c_d;
  logic [DATA_WIDTH-1:0]    reg_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]    reg_d [NUM_REGS];
  logic [DATA_WIDTH-1:0]    mem_q [MEM_WORDS];
  logic                     mem_we_s;
  logic [DATA_WIDTH:0]      wide_s;

  logic [1:0]               cls_s;
  logic [REG_ADDR_BITS-1:0] rd_s, rs1_s, rs2_s;
  logic [DATA_WIDTH-1:0]    imm_s;
  logic [3:0]               op_s;

  assign cls_s = ir_q[INSTR_WIDTH-1 -: 2];
  assign rd_s  = ir_q[4 + DATA_WIDTH + 2 * REG_ADDR_BITS +: REG_ADDR_BITS];
  assign rs1_s = ir_q[4 + DATA_WIDTH + REG_ADDR_BITS +: REG_ADDR_BITS];
  assign rs2_s = ir_q[4 + DATA_WIDTH +: REG_ADDR_BITS];
  assign imm_s = ir_q[4 +: DATA_WIDTH];
  assign op_s  = ir_q[3:0];

  // Sequencer next state, datapath latches and register/flag writeback.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    opz_d     = opz_q;
    alu_d     = alu_q;
    carry_d   = carry_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    retire_d  = 1'b0;
    illegal_d = 1'b0;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    reg_d     = reg_q;
    wide_s    = '0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d     = instr;
          state_d  = S_DECODE;
          retire_d = (instr[INSTR_WIDTH-1 -: 2] == CLS_NOP);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        opa_d = reg_q[rs1_s];
        opb_d = reg_q[rs2_s];
        opz_d = reg_q[rd_s];
        if (cls_s == CLS_NOP) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (cls_s == CLS_ALU) begin
          state_d  = S_WRITEBACK;
          retire_d = 1'b1;
          carry_d  = 1'b0;
          case (op_s)
            4'd0: begin
              wide_s  = {1'b0, opa_q} + {1'b0, opb_q};
              alu_d   = wide_s[DATA_WIDTH-1:0];
              carry_d = wide_s[DATA_WIDTH];
            end
            4'd1: begin
              // The extra MSB of the widened difference is the borrow (opA < opB).
              wide_s  = {1'b0, opa_q} - {1'b0, opb_q};
              alu_d   = wide_s[DATA_WIDTH-1:0];
              carry_d = wide_s[DATA_WIDTH];
            end
            4'd2: alu_d = opa_q & opb_q;
            4'd3: alu_d = opa_q | opb_q;
            4'd4: alu_d = opa_q ^ opb_q;
            4'd5: alu_d = {opa_q[DATA_WIDTH-2:0], 1'b0};
            4'd6: alu_d = {1'b0, opa_q[DATA_WIDTH-1:1]};
            4'd7: begin
              wide_s  = {1'b0, opa_q} + {1'b0, imm_s};
              alu_d   = wide_s[DATA_WIDTH-1:0];
              carry_d = wide_s[DATA_WIDTH];
            end
            default: begin
              illegal_d = 1'b1;
              carry_d   = carry_q;
            end
          endcase
        end else begin
          wide_s  = {1'b0, opa_q} + {1'b0, imm_s};
          addr_d  = ADDR_BITS'(wide_s);
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (cls_s == CLS_LOAD) begin
          rdata_d = mem_q[addr_q];
        end else begin
          rdata_d = rdata_q;
        end
        state_d  = S_WRITEBACK;
        retire_d = 1'b1;
      end
      S_WRITEBACK: begin
        state_d = S_IDLE;
        if (cls_s == CLS_ALU && !illegal_q) begin
          reg_d[rd_s] = alu_q;
          flag_z_d    = (alu_q == {DATA_WIDTH{1'b0}});
          flag_c_d    = carry_q;
        end else if (cls_s == CLS_LOAD) begin
          reg_d[rd_s] = rdata_q;
        end else begin
          reg_d = reg_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset restores reg i = i and clears flags/pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      opz_q     <= '0;
      alu_q     <= '0;
      carry_q   <= 1'b0;
      addr_q    <= '0;
      rdata_q   <= '0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= DATA_WIDTH'(i);
      end
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      opz_q     <= opz_d;
      alu_q     <= alu_d;
      carry_q   <= carry_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
      reg_q     <= reg_d;
    end
  end

  // Reset in the MEM cycle must suppress the write, so rst gates the enable.
  assign mem_we_s = !rst && (state_q == S_MEM) && (cls_s == CLS_STORE);

  // Data memory storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[addr_q] <= opz_q;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = reg_q[g];
  end

  assign instr_ready = (state_q == S_IDLE);
  assign retire      = retire_q;
  assign illegal_op  = illegal_q;
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;

endmodule

// File: tb/tb_param_cpu_core.sv
// Scoreboard bench for param_cpu_core: the driver queues hand-computed results per instruction,
// a monitor pops them on each retire and checks latency, illegal_op, registers and flags.
module tb_param_cpu_core;
  localparam int DW = 8;
  localparam int AB = 5;
  localparam int RA = 2;
  localparam int IW = 6 + 3 * RA + DW;

  typedef struct {
    logic [31:0] regs;
    logic        z;
    logic        c;
    logic        ill;
    int          lat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [IW-1:0]   instr;
  logic            instr_valid;
  logic            instr_ready;
  logic            retire;
  logic            illegal_op;
  logic            flag_z;
  logic            flag_c;
  logic [4*DW-1:0] regs_flat;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   n_hs = 0;
  int   n_issued = 0;
  exp_t exp_q[$];

  param_cpu_core #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .REG_ADDR_BITS(RA)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .retire(retire), .illegal_op(illegal_op),
    .flag_z(flag_z), .flag_c(flag_c), .regs_flat(regs_flat)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  function automatic logic [IW-1:0] enc(input logic [1:0] cls, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [1:0] rs2,
                                        input logic [7:0] imm, input logic [3:0] op);
    return {cls, rd, rs1, rs2, imm, op};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: post-retire state check, then pop-and-compare on retire, then handshake timestamp.
  initial begin
    exp_t cur;
    bit   post_pend;
    post_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        post_pend = 1'b0;
      end else begin
        if (post_pend) begin
          post_pend = 1'b0;
          check("regs_flat", regs_flat, cur.regs);
          check("flag_z", {31'd0, flag_z}, {31'd0, cur.z});
          check("flag_c", {31'd0, flag_c}, {31'd0, cur.c});
          check("ready_after_retire", {31'd0, instr_ready}, 32'd1);
        end
        if (retire) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_retire: got retire=1 expected no pending instruction");
          end else begin
            cur = exp_q.pop_front();
            check("latency", cyc - hs_cyc, cur.lat);
            check("illegal_op", {31'd0, illegal_op}, {31'd0, cur.ill});
            post_pend = 1'b1;
          end
        end else if (illegal_op) begin
          compared++;
          mismatched++;
          $display("FAIL illegal_without_retire: got illegal_op=1 expected 0");
        end
        if (instr_valid && instr_ready) begin
          hs_cyc = cyc;
          n_hs++;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(posedge clk); #1;
    while (!instr_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_ready) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout: got instr_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic issue(input logic [IW-1:0] ins, input logic [31:0] regs, input logic z,
                       input logic c, input logic ill, input int lat, input bit hold);
    int n = 0;
    wait_ready();
    instr = ins;
    instr_valid = 1'b1;
    exp_q.push_back('{regs, z, c, ill, lat});
    n_issued++;
    @(posedge clk); #1;
    if (hold) begin
      while (!retire && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (!retire) begin
        compared++;
        mismatched++;
        $display("FAIL retire_timeout: got retire=0 expected 1 within 50 cycles");
      end
    end
    instr_valid = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_regs", regs_flat, 32'h03020100);
    check("rst_flag_z", {31'd0, flag_z}, 32'd0);
    check("rst_flag_c", {31'd0, flag_c}, 32'd0);
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_retire", {31'd0, retire}, 32'd0);
  endtask

  task automatic do_reset();
    wait_ready();
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state();
  endtask

  initial begin
    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();

    issue(enc(2'b01, 2'd1, 2'd2, 2'd3, 8'h00, 4'd0), 32'h03020500, 1'b0, 1'b0, 1'b0, 3, 1'b0);

    do_reset();
    issue(enc(2'b01, 2'd0, 2'd1, 2'd2, 8'h00, 4'd1), 32'h030201FF, 1'b0, 1'b1, 1'b0, 3, 1'b0);
    issue(enc(2'b01, 2'd2, 2'd3, 2'd3, 8'h00, 4'd4), 32'h030001FF, 1'b1, 1'b0, 1'b0, 3, 1'b0);
    issue(enc(2'b01, 2'd0, 2'd0, 2'd0, 8'h00, 4'd5), 32'h030001FE, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    issue(enc(2'b01, 2'd3, 2'd0, 2'd0, 8'h00, 4'd6), 32'h7F0001FE, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    issue(enc(2'b01, 2'd1, 2'd3, 2'd0, 8'h00, 4'd2), 32'h7F007EFE, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    issue(enc(2'b01, 2'd2, 2'd1, 2'd3, 8'h00, 4'd3), 32'h7F7F7EFE, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    issue(enc(2'b01, 2'd0, 2'd2, 2'd3, 8'h00, 4'd1), 32'h7F7F7E00, 1'b1, 1'b0, 1'b0, 3, 1'b0);

    do_reset();
    issue(enc(2'b11, 2'd3, 2'd2, 2'd0, 8'h1F, 4'd0), 32'h03020100, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    issue(enc(2'b10, 2'd0, 2'd1, 2'd0, 8'h00, 4'd0), 32'h03020103, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    issue(enc(2'b01, 2'd2, 2'd0, 2'd0, 8'h00, 4'd4), 32'h03000103, 1'b1, 1'b0, 1'b0, 3, 1'b0);
    issue(enc(2'b01, 2'd1, 2'd2, 2'd3, 8'h00, 4'd9), 32'h03000103, 1'b1, 1'b0, 1'b1, 3, 1'b1);
    issue(enc(2'b01, 2'd0, 2'd1, 2'd1, 8'h00, 4'd15), 32'h03000103, 1'b1, 1'b0, 1'b1, 3, 1'b0);

    do_reset();
    issue(enc(2'b11, 2'd2, 2'd0, 2'd0, 8'h05, 4'd0), 32'h03020100, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    issue(enc(2'b01, 2'd3, 2'd0, 2'd0, 8'h3C, 4'd7), 32'h3C020100, 1'b0, 1'b0, 1'b0, 3, 1'b0);

    // Store r3=0x3C to addr 5, then reset during its MEM cycle.
    wait_ready();
    instr = enc(2'b11, 2'd3, 2'd0, 2'd0, 8'h05, 4'd0);
    instr_valid = 1'b1;
    n_issued++;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state();

    issue(enc(2'b10, 2'd1, 2'd0, 2'd0, 8'h05, 4'd0), 32'h03020200, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    issue(enc(2'b00, 2'd0, 2'd0, 2'd0, 8'h00, 4'd0), 32'h03020200, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    issue(enc(2'b01, 2'd1, 2'd3, 2'd0, 8'hFE, 4'd7), 32'h03020100, 1'b0, 1'b1, 1'b0, 3, 1'b0);
    issue(enc(2'b10, 2'd2, 2'd0, 2'd0, 8'h05, 4'd0), 32'h03020100, 1'b0, 1'b1, 1'b0, 4, 1'b0);
    issue(enc(2'b01, 2'd0, 2'd0, 2'd0, 8'h00, 4'd7), 32'h03020100, 1'b1, 1'b0, 1'b0, 3, 1'b0);

    wait_ready();
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("handshake_count", n_hs, n_issued);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
